match_sequencer: RTL and testbench

Top-level game-phase controller for the quidditch pitch. It sequences a match through kickoff, play, goal pause and game over, and divides clk into a seconds tick to count down match time. It accumulates team scores from goal pulses produced by the game controller, and gates player and ball movement. Its outputs drive the game controller (play_en, ball_reset) and the VGA controller (time_left, scores, winner).

---
 rtl/match_sequencer_pkg.sv | 42 ++++
 rtl/match_sequencer_if.sv | 25 ++
 rtl/match_sequencer_sec_prescaler.sv | 30 +++
 rtl/match_sequencer.sv | 166 ++++++++++++++++
 tb/tb_match_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/match_sequencer_pkg.sv
// Shared types and defaults for the match sequencer and the VGA score display.
// The optional OVERTIME state is only reachable when OVERTIME_EN is defined.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KICKOFF    = 3'd1,
    PLAY       = 3'd2,
    GOAL_PAUSE = 3'd3,
    GAME_OVER  = 3'd4,
    OVERTIME   = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_BLUE = 2'b01,
    WIN_RED  = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam int DEF_GOAL_POINTS   = 10;
  localparam int DEF_SCORE_MAX     = 120;
  localparam int DEF_MATCH_SECONDS = 180;
  localparam int SCORE_W           = 7;
  localparam int TIME_W            = 8;

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] score,
                                                input int points, input int maxScore);
    int sum;
    sum = int'(score) + points;
    if (sum > maxScore) return SCORE_W'(maxScore);
    return SCORE_W'(sum);
  endfunction

  function automatic winner_t decideWinner(input logic [SCORE_W-1:0] blue,
                                           input logic [SCORE_W-1:0] red);
    if (blue > red) return WIN_BLUE;
    if (red > blue) return WIN_RED;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Game-controller side of the match sequencer: goal/start pulses in, phase,
// timer and score state out. master = game controller, slave = sequencer.
interface match_sequencer_if;
  logic       start;
  logic       goal_blue;
  logic       goal_red;
  logic [7:0] time_left;
  logic [6:0] blue_score;
  logic [6:0] red_score;
  logic       play_en;
  logic       ball_reset;
  logic [2:0] phase;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, goal_blue, goal_red,
    input  time_left, blue_score, red_score, play_en, ball_reset, phase, game_over, winner
  );

  modport slave (
    input  start, goal_blue, goal_red,
    output time_left, blue_score, red_score, play_en, ball_reset, phase, game_over, winner
  );
endinterface

// File: rtl/match_sequencer_sec_prescaler.sv
// Divides clk into a one-cycle tick every TICKS_PER_SECOND cycles while run_i
// is high; also reused as the VGA blink timer.
module sec_prescaler #(
  parameter int TICKS_PER_SECOND = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SECOND - 1);

  logic [CW-1:0] count_q;

  assign tick_o = run_i && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i || !run_i || (count_q == LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Quidditch match phase controller: kickoff, play, goal pauses, countdown and
// scoring. Define OVERTIME_EN to break ties with a sudden-death OVERTIME phase.
module match_sequencer
  import match_pkg::*;
#(
  parameter int TICKS_PER_SECOND   = 50000000,
  parameter int MATCH_SECONDS      = DEF_MATCH_SECONDS,
  parameter int GOAL_PAUSE_SECONDS = 3,
  parameter int KICKOFF_SECONDS    = 2,
  parameter int GOAL_POINTS        = DEF_GOAL_POINTS,
  parameter int SCORE_MAX          = DEF_SCORE_MAX
) (
  input logic              clk,
  input logic              rst_n,
  match_sequencer_if.slave bus
);

  localparam logic [TIME_W-1:0] MATCH_T   = TIME_W'(MATCH_SECONDS);
  localparam logic [3:0]        KICK_T    = 4'(KICKOFF_SECONDS);
  localparam logic [3:0]        PAUSE_T   = 4'(GOAL_PAUSE_SECONDS);

  phase_t              phase_q, phase_d;
  logic [TIME_W-1:0]   timeLeft_q, timeLeft_d;
  logic [SCORE_W-1:0]  blueScore_q, blueScore_d, redScore_q, redScore_d;
  logic [SCORE_W-1:0]  blueAdd, redAdd;
  logic [3:0]          pause_q, pause_d;
  logic                fromOvertime_q, fromOvertime_d;
  logic                ballPend_q, ballPend_d;
  logic                ballReset_q, playEn_q, gameOver_q;
  winner_t             winner_q, winner_d;
  logic                secTick, tickRun, tickClear, expiring;

  assign tickRun   = (phase_q == KICKOFF) || (phase_q == PLAY) ||
                     (phase_q == GOAL_PAUSE) || (phase_q == OVERTIME);
  assign tickClear = (phase_d != phase_q);
  assign expiring  = secTick && (timeLeft_q == TIME_W'(1));
  assign blueAdd   = bus.goal_blue ? satAdd(blueScore_q, GOAL_POINTS, SCORE_MAX) : blueScore_q;
  assign redAdd    = bus.goal_red  ? satAdd(redScore_q,  GOAL_POINTS, SCORE_MAX) : redScore_q;

  sec_prescaler #(
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(tickClear),
    .run_i  (tickRun),
    .tick_o (secTick)
  );

  always_comb begin
    phase_d        = phase_q;
    timeLeft_d     = timeLeft_q;
    blueScore_d    = blueScore_q;
    redScore_d     = redScore_q;
    pause_d        = pause_q;
    fromOvertime_d = fromOvertime_q;
    winner_d       = winner_q;
    ballPend_d     = 1'b0;

    case (phase_q)
      IDLE, GAME_OVER: begin
        if (bus.start) begin
          phase_d        = KICKOFF;
          blueScore_d    = '0;
          redScore_d     = '0;
          timeLeft_d     = MATCH_T;
          pause_d        = KICK_T;
          fromOvertime_d = 1'b0;
          winner_d       = WIN_NONE;
          ballPend_d     = 1'b1;
        end
      end

      KICKOFF, GOAL_PAUSE: begin
        if (secTick) begin
          pause_d = pause_q - 4'd1;
          if (pause_q == 4'd1) begin
            phase_d        = fromOvertime_q ? OVERTIME : PLAY;
            fromOvertime_d = 1'b0;
          end
        end
      end

      PLAY: begin
        blueScore_d = blueAdd;
        redScore_d  = redAdd;
        if (secTick && (timeLeft_q != '0)) timeLeft_d = timeLeft_q - TIME_W'(1);
        // Expiry wins over a same-cycle goal: credit it, but take no pause.
        if (expiring) begin
          phase_d  = GAME_OVER;
          winner_d = decideWinner(blueAdd, redAdd);
`ifdef OVERTIME_EN
          if (blueAdd == redAdd) begin
            phase_d  = OVERTIME;
            winner_d = WIN_NONE;
          end
`endif
        end else if (bus.goal_blue || bus.goal_red) begin
          phase_d    = GOAL_PAUSE;
          pause_d    = PAUSE_T;
          ballPend_d = 1'b1;
        end
      end

`ifdef OVERTIME_EN
      OVERTIME: begin
        blueScore_d = blueAdd;
        redScore_d  = redAdd;
        if (bus.goal_blue && bus.goal_red) begin
          phase_d        = GOAL_PAUSE;
          pause_d        = PAUSE_T;
          fromOvertime_d = 1'b1;
          ballPend_d     = 1'b1;
        end else if (bus.goal_blue) begin
          phase_d  = GAME_OVER;
          winner_d = WIN_BLUE;
        end else if (bus.goal_red) begin
          phase_d  = GAME_OVER;
          winner_d = WIN_RED;
        end
      end
`endif

      default: phase_d = IDLE;
    endcase
  end

  // ball_reset trails the transition by one cycle via ballPend_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= IDLE;
      timeLeft_q     <= MATCH_T;
      blueScore_q    <= '0;
      redScore_q     <= '0;
      pause_q        <= '0;
      fromOvertime_q <= 1'b0;
      winner_q       <= WIN_NONE;
      ballPend_q     <= 1'b0;
      ballReset_q    <= 1'b0;
      playEn_q       <= 1'b0;
      gameOver_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      timeLeft_q     <= timeLeft_d;
      blueScore_q    <= blueScore_d;
      redScore_q     <= redScore_d;
      pause_q        <= pause_d;
      fromOvertime_q <= fromOvertime_d;
      winner_q       <= winner_d;
      ballPend_q     <= ballPend_d;
      ballReset_q    <= ballPend_q;
      playEn_q       <= (phase_d == PLAY) || (phase_d == OVERTIME);
      gameOver_q     <= (phase_d == GAME_OVER);
    end
  end

  assign bus.phase      = phase_q;
  assign bus.time_left  = timeLeft_q;
  assign bus.blue_score = blueScore_q;
  assign bus.red_score  = redScore_q;
  assign bus.play_en    = playEn_q;
  assign bus.ball_reset = ballReset_q;
  assign bus.game_over  = gameOver_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer with a 4-cycle second, 5 s match,
// 2 s kickoff and 3 s goal pause; tie expectations follow OVERTIME_EN.
module tb_match_sequencer;

  typedef struct packed {
    logic [2:0] phase;
    logic [7:0] timeLeft;
    logic [6:0] blue;
    logic [6:0] red;
    logic       playEn;
    logic       ballReset;
    logic       gameOver;
    logic [1:0] winner;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b1;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  bit    monOn  = 1'b0;
  int    p      = 0;
  snap_t prevSnap;
  snap_t rstSnap;
  exp_t  expQ[$];

  match_sequencer_if bus();

  match_sequencer #(
    .TICKS_PER_SECOND  (4),
    .MATCH_SECONDS     (5),
    .GOAL_PAUSE_SECONDS(3),
    .KICKOFF_SECONDS   (2),
    .GOAL_POINTS       (10),
    .SCORE_MAX         (120)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mkSnap(int ph, int tl, int b, int r, int pe, int br, int go, int w);
    snap_t s;
    s.phase     = 3'(ph);
    s.timeLeft  = 8'(tl);
    s.blue      = 7'(b);
    s.red       = 7'(r);
    s.playEn    = 1'(pe);
    s.ballReset = 1'(br);
    s.gameOver  = 1'(go);
    s.winner    = 2'(w);
    return s;
  endfunction

  function automatic snap_t sampleDut();
    snap_t s;
    s.phase     = bus.phase;
    s.timeLeft  = bus.time_left;
    s.blue      = bus.blue_score;
    s.red       = bus.red_score;
    s.playEn    = bus.play_en;
    s.ballReset = bus.ball_reset;
    s.gameOver  = bus.game_over;
    s.winner    = bus.winner;
    return s;
  endfunction

  function automatic string fmtSnap(snap_t s);
    return $sformatf("ph=%0d tl=%0d blue=%0d red=%0d play=%0b br=%0b go=%0b win=%b",
                     s.phase, s.timeLeft, s.blue, s.red, s.playEn, s.ballReset, s.gameOver, s.winner);
  endfunction

  task automatic expectAt(int c, snap_t s);
    exp_t e;
    e.cyc = c;
    e.s   = s;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(logic st, logic gb, logic gr);
    bus.start     = st;
    bus.goal_blue = gb;
    bus.goal_red  = gr;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.goal_blue = 1'b0;
    bus.goal_red  = 1'b0;
  endtask

  task automatic checkOutput(string name, snap_t want);
    snap_t got;
    got = sampleDut();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got {%s} want {%s}", name, fmtSnap(got), fmtSnap(want));
    end
  endtask

  task automatic waitUntil(int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic startMatch();
    int c0;
    c0 = cyc;
    expectAt(c0 + 1, mkSnap(1, 5, 0, 0, 0, 0, 0, 0));
    expectAt(c0 + 2, mkSnap(1, 5, 0, 0, 0, 1, 0, 0));
    expectAt(c0 + 3, mkSnap(1, 5, 0, 0, 0, 0, 0, 0));
    expectAt(c0 + 9, mkSnap(2, 5, 0, 0, 1, 0, 0, 0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    p = c0 + 9;
  endtask

  // A goal one cycle into PLAY never lands on a tick, so time_left is unchanged.
  task automatic goalRound(logic gb, logic gr, int tl, int nb, int nr);
    waitUntil(p + 1);
    expectAt(p + 2,  mkSnap(3, tl, nb, nr, 0, 0, 0, 0));
    expectAt(p + 3,  mkSnap(3, tl, nb, nr, 0, 1, 0, 0));
    expectAt(p + 4,  mkSnap(3, tl, nb, nr, 0, 0, 0, 0));
    expectAt(p + 14, mkSnap(2, tl, nb, nr, 1, 0, 0, 0));
    applyStimulus(1'b0, gb, gr);
    p = p + 14;
  endtask

  task automatic expireWithGoal(logic gb, logic gr, snap_t want);
    waitUntil(p + 19);
    expectAt(p + 20, want);
    applyStimulus(1'b0, gb, gr);
  endtask

  // Monitor: any change of phase, ball_reset, scores or winner is an output event.
  always @(negedge clk) begin
    if (monOn) begin
      snap_t cur;
      exp_t  e;
      cur = sampleDut();
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_event: at cycle %0d got nothing, want {%s} at cycle %0d",
                 cyc, fmtSnap(e.s), e.cyc);
      end
      if (cur.phase !== prevSnap.phase || cur.ballReset !== prevSnap.ballReset ||
          cur.blue !== prevSnap.blue || cur.red !== prevSnap.red ||
          cur.gameOver !== prevSnap.gameOver || cur.winner !== prevSnap.winner) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: got {%s} at cycle %0d, want no change", fmtSnap(cur), cyc);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cyc || e.s !== cur) begin
            errors++;
            $display("[TB] FAIL event: got {%s} at cycle %0d, want {%s} at cycle %0d",
                     fmtSnap(cur), cyc, fmtSnap(e.s), e.cyc);
          end
        end
      end
      prevSnap = cur;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start     = 1'b0;
    bus.goal_blue = 1'b0;
    bus.goal_red  = 1'b0;
    rstSnap = mkSnap(0, 5, 0, 0, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    #1 checkOutput("reset_init", rstSnap);
    @(negedge clk);
    rst_n    = 1'b1;
    prevSnap = rstSnap;
    monOn    = 1'b1;
    @(negedge clk);

    // Match 1: kickoff, 13 blue goals (second one simultaneous), saturation, expiry with a red goal.
    startMatch();
    for (int i = 0; i < 13; i++) begin
      goalRound(1'b1, (i == 1), 5, ((i + 1) * 10 > 120) ? 120 : (i + 1) * 10, (i >= 1) ? 10 : 0);
    end
    expireWithGoal(1'b0, 1'b1, mkSnap(4, 0, 120, 20, 0, 0, 1, 1));
    repeat (5) @(negedge clk);

    // Match 2: restart from GAME_OVER; start and goals during KICKOFF are ignored.
    startMatch();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    goalRound(1'b0, 1'b1, 5, 0, 10);
    expireWithGoal(1'b0, 1'b1, mkSnap(4, 0, 0, 20, 0, 0, 1, 2));
    repeat (5) @(negedge clk);

    // Match 3: 0:0 expiry.
    startMatch();
`ifdef OVERTIME_EN
    expectAt(p + 20, mkSnap(5, 0, 0, 0, 1, 0, 0, 0));
    waitUntil(p + 22);
    expectAt(p + 23, mkSnap(4, 0, 10, 0, 0, 0, 1, 1));
    applyStimulus(1'b0, 1'b1, 1'b0);
`else
    expectAt(p + 20, mkSnap(4, 0, 0, 0, 0, 0, 1, 3));
    waitUntil(p + 21);
`endif
    repeat (5) @(negedge clk);

    // Match 4: asynchronous reset in the middle of a goal pause.
    startMatch();
    waitUntil(p + 1);
    expectAt(p + 2, mkSnap(3, 5, 10, 0, 0, 0, 0, 0));
    expectAt(p + 3, mkSnap(3, 5, 10, 0, 0, 1, 0, 0));
    expectAt(p + 4, mkSnap(3, 5, 10, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitUntil(p + 6);
    @(posedge clk);
    #2;
    expectAt(cyc, rstSnap);
    rst_n = 1'b0;
    #1 checkOutput("reset_async", rstSnap);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events: got %0d outstanding, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
